// File: rtl/key_debounce_if.sv
// Key-conditioning signal bundle: raw pins and event clears in, clean levels,
// edge pulses and sticky event flags out.
interface key_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] keys_raw;
    logic [WIDTH-1:0] event_clr;
    logic [WIDTH-1:0] key_level;
    logic [WIDTH-1:0] key_press;
    logic [WIDTH-1:0] key_release;
    logic [WIDTH-1:0] key_event;

    // Level/pulse interface with no handshake: outputs are registered and
    // valid every cycle; event_clr is a plain per-cycle strobe.
    modport master (
        output keys_raw,
        output event_clr,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_event
    );

    modport slave (
        input  keys_raw,
        input  event_clr,
        output key_level,
        output key_press,
        output key_release,
        output key_event
    );
endinterface

// File: rtl/key_debounce_sync.sv
// Per-channel synchroniser, polarity normalisation and debounce for board keys,
// producing clean levels, press/release pulses and software-cleared event flags.
module key_debounce_sync #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    key_debounce_if.slave  bus
);

    // Pin level of a released key; also the XOR mask that makes s active-high.
    localparam logic [WIDTH-1:0] IDLE_PIN = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [CNT_W-1:0] cnt    [WIDTH];
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] press_q;
    logic [WIDTH-1:0] release_q;
    logic [WIDTH-1:0] event_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= IDLE_PIN;
        end else begin
            sync_q[0] <= bus.keys_raw;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ IDLE_PIN;

    // One cycle of agreement with the current level clears the count, so a
    // change needs DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            event_q   <= '0;
        end else begin
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == level_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    cnt[i]       <= '0;
                    level_q[i]   <= s[i];
                    press_q[i]   <= s[i];
                    release_q[i] <= ~s[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            // A press pulse wins over a simultaneous clear.
            event_q <= press_q | (event_q & ~bus.event_clr);
        end
    end

    assign bus.key_level   = level_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;
    assign bus.key_event   = event_q;

endmodule
